// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the LFSR byte source.
package lfsr_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [7:0]  DEFAULT_TAPS = 8'hB8;
  localparam logic [7:0]  DEFAULT_SEED = 8'h01;
  localparam int unsigned MAX_W        = 32;

  // Galois step on a zero-extended state; callers truncate to their own width.
  function automatic logic [MAX_W-1:0] lfsr_next(input logic [MAX_W-1:0] state,
                                                 input logic [MAX_W-1:0] taps);
    return state[0] ? ((state >> 1) ^ taps) : (state >> 1);
  endfunction

endpackage

// File: rtl/lfsr_byte_source_core.sv
// Galois LFSR register with step enable and lock-up-safe seed load.
import lfsr_pkg::*;

module lfsr_core #(
  parameter int unsigned       WIDTH = 8,
  parameter logic [WIDTH-1:0]  TAPS  = WIDTH'(DEFAULT_TAPS),
  parameter logic [WIDTH-1:0]  SEED  = WIDTH'(DEFAULT_SEED)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] step_val;

  always_comb begin
    load_val = (seed_in == '0) ? WIDTH'(1) : seed_in;
    step_val = WIDTH'(lfsr_next(MAX_W'(q), MAX_W'(TAPS)));
  end

  always_ff @(posedge clk) begin
    if (rst)       q <= SEED;
    else if (load) q <= load_val;
    else if (step) q <= step_val;
  end

endmodule

// File: rtl/lfsr_byte_source.sv
// Bounded, seedable pseudo-random word source with valid/ready handshake.
import lfsr_pkg::*;

module lfsr_byte_source #(
  parameter int unsigned       WIDTH   = 8,
  parameter logic [WIDTH-1:0]  TAPS    = WIDTH'(DEFAULT_TAPS),
  parameter logic [WIDTH-1:0]  SEED    = WIDTH'(DEFAULT_SEED),
  parameter int unsigned       COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               seed_load,
  input  logic [WIDTH-1:0]   seed_in,
  input  logic [COUNT_W-1:0] num_samples,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   a,
  output logic               a_valid,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] sample_count
);

  state_t             state;
  logic [COUNT_W-1:0] target;
  logic [COUNT_W-1:0] count_inc;
  logic               xfer;
  logic               load;

  always_comb begin
    a_valid   = (state == RUN);
    busy      = (state == RUN);
    done      = (state == DONE);
    xfer      = a_valid && out_ready;
    load      = (state == IDLE) && seed_load;
    count_inc = sample_count + COUNT_W'(1);
  end

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .step    (xfer),
    .load    (load),
    .seed_in (seed_in),
    .q       (a)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      target       <= '0;
      sample_count <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          target       <= num_samples;
          sample_count <= '0;
          state        <= (num_samples == '0) ? DONE : RUN;
        end
        RUN: if (xfer) begin
          sample_count <= count_inc;
          if (count_inc == target) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
